// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel coordinates, sync, data-enable and start strobes.
// Optional frames-completed counter output enabled by defining VTG_FRAME_CNT_EN.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter bit          H_POL    = 1'b1,
    parameter bit          V_POL    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic        o_line_start,
    output logic        o_frame_start
`ifdef VTG_FRAME_CNT_EN
    ,
    output logic [15:0] o_frame_cnt
`endif
);

    localparam logic [15:0] H_LAST   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] V_LAST   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
    localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

    logic [15:0] h_cnt_q, h_cnt_d;
    logic [15:0] v_cnt_q, v_cnt_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic        ls_q, ls_d;
    logic        fs_q, fs_d;
`ifdef VTG_FRAME_CNT_EN
    logic [15:0] fc_q, fc_d;
    logic        started_q, started_d;
`endif

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        de_d    = de_q;
        ls_d    = ls_q;
        fs_d    = fs_q;
`ifdef VTG_FRAME_CNT_EN
        fc_d      = fc_q;
        started_d = started_q;
`endif
        if (i_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 16'd1;
            end else begin
                h_cnt_d = h_cnt_q + 16'd1;
            end
            // Outputs decode the pre-increment counters, so they trail by one strobe.
            x_d  = h_cnt_q;
            y_d  = v_cnt_q;
            de_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
            ls_d = (h_cnt_q == '0);
            fs_d = (h_cnt_q == '0) && (v_cnt_q == '0);
            hs_d = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? H_POL : ~H_POL;
            vs_d = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? V_POL : ~V_POL;
`ifdef VTG_FRAME_CNT_EN
            // The first frame after reset is frame 0; only later frame starts count.
            if ((h_cnt_q == '0) && (v_cnt_q == '0)) begin
                started_d = 1'b1;
                if (started_q) fc_d = fc_q + 16'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hs_q    <= ~H_POL;
            vs_q    <= ~V_POL;
            de_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
`ifdef VTG_FRAME_CNT_EN
            fc_q      <= '0;
            started_q <= 1'b0;
`endif
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
`ifdef VTG_FRAME_CNT_EN
            fc_q      <= fc_d;
            started_q <= started_d;
`endif
        end
    end

    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_hsync       = hs_q;
    assign o_vsync       = vs_q;
    assign o_de          = de_q;
    assign o_line_start  = ls_q;
    assign o_frame_start = fs_q;
`ifdef VTG_FRAME_CNT_EN
    assign o_frame_cnt   = fc_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with a reduced raster; expectations come from the strobe
// count since reset, mapped to raster position with plain arithmetic.
module tb_video_timing_gen;

    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HSW = 3;
    localparam int HBP = 2;
    localparam int VA  = 5;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 1;
    localparam bit HP  = 1'b1;
    localparam bit VP  = 1'b0;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int FT  = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_en = 1'b0;
    logic [15:0] o_x, o_y;
    logic        o_hsync, o_vsync, o_de, o_line_start, o_frame_start;
`ifdef VTG_FRAME_CNT_EN
    logic [15:0] o_frame_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;
    int k = 0;  // strobes accepted since the last reset

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .H_POL(HP), .V_POL(VP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_en(i_en),
        .o_x(o_x),
        .o_y(o_y),
        .o_hsync(o_hsync),
        .o_vsync(o_vsync),
        .o_de(o_de),
        .o_line_start(o_line_start),
        .o_frame_start(o_frame_start)
`ifdef VTG_FRAME_CNT_EN
        ,
        .o_frame_cnt(o_frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int model_x();
        return (k == 0) ? 0 : ((k - 1) % FT) % HT;
    endfunction

    task automatic check1(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d at k=%0d", tag, obs, exp, k);
        end
    endtask

    task automatic check_all();
        int p, x, y;
        logic de, ls, fs, hs, vs;
        logic [15:0] fc;
        if (k == 0) begin
            x = 0; y = 0; de = 0; ls = 0; fs = 0; hs = ~HP; vs = ~VP; fc = 16'd0;
        end else begin
            p  = (k - 1) % FT;
            x  = p % HT;
            y  = p / HT;
            de = (x < HA) && (y < VA);
            ls = (x == 0);
            fs = (p == 0);
            hs = (x >= HA + HFP && x < HA + HFP + HSW) ? HP : ~HP;
            vs = (y >= VA + VFP && y < VA + VFP + VSW) ? VP : ~VP;
            fc = 16'((k - 1) / FT);
        end
        check1("x", o_x, 16'(x));
        check1("y", o_y, 16'(y));
        check1("de", {15'd0, o_de}, {15'd0, de});
        check1("line_start", {15'd0, o_line_start}, {15'd0, ls});
        check1("frame_start", {15'd0, o_frame_start}, {15'd0, fs});
        check1("hsync", {15'd0, o_hsync}, {15'd0, hs});
        check1("vsync", {15'd0, o_vsync}, {15'd0, vs});
`ifdef VTG_FRAME_CNT_EN
        check1("frame_cnt", o_frame_cnt, fc);
`endif
    endtask

    task automatic cyc(input logic en, input logic r);
        i_en = en;
        rst  = r;
        @(posedge clk);
        if (r) k = 0;
        else if (en) k++;
        #1;
        check_all();
    endtask

    initial begin
        // Reset for four clocks, with a stray strobe to confirm reset priority
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);

        // First strobe shows the origin, then two full lines continuously
        for (int i = 0; i < 2 * HT; i++) cyc(1'b1, 1'b0);

        // Randomly gated strobes
        for (int i = 0; i < 300; i++) cyc(($urandom_range(0, 3) != 0), 1'b0);

        // Hold mid-line: strobe, gap of two, strobe
        for (int i = 0; i < FT && model_x() != 5; i++) cyc(1'b1, 1'b0);
        check1("hold_pos", o_x, 16'd5);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check1("hold_x", o_x, 16'd5);
        cyc(1'b1, 1'b0);
        check1("after_hold_x", o_x, 16'd6);

        // Reset while hsync is active, then recovery
        for (int i = 0; i < FT && model_x() != HA + HFP + 1; i++) cyc(1'b1, 1'b0);
        check1("hs_pos_hsync", {15'd0, o_hsync}, {15'd0, HP});
        cyc(1'b1, 1'b1);
        check1("rst_hsync", {15'd0, o_hsync}, {15'd0, ~HP});
        check1("rst_x", o_x, 16'd0);
        cyc(1'b1, 1'b0);
        check1("recover_fs", {15'd0, o_frame_start}, 16'd1);

        // Three full frames plus a margin, continuous strobes
        for (int i = 0; i < 3 * FT + 5; i++) cyc(1'b1, 1'b0);

        // Random strobes with occasional resets
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 4) != 0), ($urandom_range(0, 99) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
